locked_seq_core: RTL and testbench
==================================

// Module: locked_seq_core
// PURPOSE
//  Parametrised key-locked sequential core: a STATE_W-bit feedback state machine whose next-state and
//  output bits each pass through a key gate (XOR/XNOR per KEY_POL). The key is loaded serially through a
//  start/valid handshake into an internal key register. The core runs only once a full key is held.
//  Successor to the fixed-width locked benchmarks: widths, taps and key polarity are parameters.
//  Adds on-chip key loading, run gating and re-keying, which those benchmarks lack.
// PARAMETERS
//  STATE_W     3        state register width (>=2)
//  IN_W        4        primary input width
//  OUT_W       1        primary output width (<=STATE_W)
//  KEY_W       STATE_W+OUT_W  key length; bits [STATE_W-1:0] gate next-state, [KEY_W-1:STATE_W] gate outputs
//  TAPS        3'b110   feedback taps into state parity (STATE_W bits)
//  KEY_POL     4'b1011  gate polarity per key bit; the correct key equals KEY_POL
//  RESET_STATE 3'b000   state value after reset and on every key_start
// PORTS
//  CK         in   1       clock, all logic on rising edge
//  RST        in   1       synchronous reset, active-high
//  G          in   IN_W    primary inputs, sampled every RUN cycle
//  key_start  in   1       begin key load (aborts RUN)
//  key_valid  in   1       key_bit is valid this cycle
//  key_bit    in   1       serial key bit, first bit lands in key_r[KEY_W-1]
//  key_busy   out  1       1 while in LOAD
//  out_valid  out  1       1 while in RUN
//  out        out  OUT_W   gated primary outputs; 0 when out_valid=0
// BEHAVIOUR
//  Reset: RST=1 at an edge -> fsm=IDLE, state=RESET_STATE, key_r=0, cnt=0; key_busy=0, out_valid=0, out=0.
//  FSM: IDLE -key_start-> LOAD; LOAD -(key_valid & cnt==KEY_W-1)-> RUN; RUN -key_start-> LOAD.
//   key_start in LOAD restarts the load: cnt=0, key_r cleared.
//  On key_start (any state): state<=RESET_STATE, cnt<=0, key_r<=0. key_start beats key_valid in the same cycle
//   (that key_bit is dropped).
//  LOAD: key_valid -> key_r<={key_r[KEY_W-2:0],key_bit}, cnt++. key_valid=0 -> hold. State frozen.
//   Entry to RUN is at the edge that takes the KEY_W-th bit. out_valid=1 from the next cycle.
//  RUN, every cycle:
//   fb  = ^(state & TAPS) ^ ^G
//   raw = {state[STATE_W-2:0], fb}
//   state <= raw ^ key_r[STATE_W-1:0] ^ KEY_POL[STATE_W-1:0]
//  out[j] = (~state[STATE_W-1-j]) ^ key_r[STATE_W+j] ^ KEY_POL[STATE_W+j]; combinational from registers,
//   forced 0 outside RUN.
//  Wrong key: no error flag. The core runs with corrupted next-state/out, by design.
//  key_valid in IDLE/RUN without key_start is ignored. G is ignored outside RUN.
//  All widths are exact and no arithmetic wraps, except cnt: $clog2(KEY_W+1) bits, it never exceeds KEY_W-1.
// STRUCTURE
//  Shared package lsc_pkg: typedef enum {IDLE,LOAD,RUN} lsc_state_t; function lsc_key_gate(raw,key,pol).
//  One sub-module: lsc_key_shift_reg (KEY_W shift register + cnt + done pulse).
//  Top holds FSM, state register and gates.
// TESTING (defaults unless stated)
//  1 Reset: RST high 2 cycles -> key_busy=0, out_valid=0, out=0, state=000; any G has no effect.
//  2 Correct key: key_start, then bits 1,0,1,1 on consecutive cycles -> RUN after 4th. With G=4'b0001:
//    state 000->001, out=1. Next G=0 -> state 010 (fb=0).
//  3 Wrong key 1010: key_start + bits 1,0,1,0, G=0001 in RUN -> state stays 000 (raw 001 ^ 001), out=1.
//    Key 0011 -> out=0.
//  4 Load stall and abort: bits 1,0 with gaps where key_valid=0, then key_start -> cnt=0, key_r=0.
//    Reload 1011 -> same trace as test 2.
//  5 Re-key mid-RUN: in RUN with state=010, assert key_start -> next cycle key_busy=1, out_valid=0,
//    out=0, state=000.
//  6 RST mid-LOAD after 2 bits -> IDLE, key_r=0; a key_valid pulse in IDLE changes nothing.

Source files
------------

// File: rtl/lsc_pkg.sv
// Shared definitions for the key-locked sequential core.
//   lsc_state_t  : control FSM states (IDLE, LOAD, RUN)
//   lsc_key_gate : one key gate bit; XOR with the key bit, inverted when
//                  the polarity bit is 1 (i.e. XNOR), so the gate is
//                  transparent exactly when key == pol.
package lsc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } lsc_state_t;

  function automatic logic lsc_key_gate(input logic raw, input logic key, input logic pol);
    return raw ^ key ^ pol;
  endfunction

endpackage

// File: rtl/lsc_key_shift_reg.sv
// Serial key register for locked_seq_core.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (clears key and count)
//   clr      in   restart a load: clears key and count
//   shift_en in   shift bit_in in as the new LSB, advance the count
//   bit_in   in   serial key bit; the first bit ends up in key[KEY_W-1]
//   key      out  current key register contents
//   done     out  combinational pulse on the shift that takes the KEY_W-th bit
module lsc_key_shift_reg #(
  parameter int unsigned KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] key,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W - 1);

  logic [KEY_W-1:0] key_r;
  logic [CNT_W-1:0] cnt;

  assign key  = key_r;
  assign done = shift_en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      key_r <= '0;
      cnt   <= '0;
    end else if (shift_en) begin
      key_r <= {key_r[KEY_W-2:0], bit_in};
      // The count returns to 0 on the last bit so it never reaches KEY_W.
      cnt   <= done ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/locked_seq_core.sv
// Key-locked sequential core.
// A STATE_W-bit feedback state machine whose next-state and output bits
// each pass through a key gate. The key is shifted in serially after
// key_start; the core only advances once a full key is held. A wrong key
// is not flagged: the core simply runs with corrupted next-state/outputs.
//   CK        in   clock, rising edge
//   RST       in   synchronous active-high reset
//   G         in   primary inputs, used only in RUN
//   key_start in   begin (or restart) a key load; aborts RUN
//   key_valid in   key_bit valid this cycle (used only in LOAD)
//   key_bit   in   serial key bit, MSB first
//   key_busy  out  1 while loading the key
//   out_valid out  1 while running
//   out       out  gated primary outputs, 0 when out_valid=0
module locked_seq_core
  import lsc_pkg::*;
#(
  parameter int unsigned         STATE_W     = 3,
  parameter int unsigned         IN_W        = 4,
  parameter int unsigned         OUT_W       = 1,
  parameter int unsigned         KEY_W       = STATE_W + OUT_W,
  parameter logic [STATE_W-1:0]  TAPS        = 3'b110,
  parameter logic [KEY_W-1:0]    KEY_POL     = 4'b1011,
  parameter logic [STATE_W-1:0]  RESET_STATE = 3'b000
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [IN_W-1:0]  G,
  input  logic             key_start,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_busy,
  output logic             out_valid,
  output logic [OUT_W-1:0] out
);

  lsc_state_t         fsm;
  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_nxt;
  logic [KEY_W-1:0]   key_r;
  logic               shift_en;
  logic               key_done;
  logic               fb;
  logic [STATE_W-1:0] raw;

  // key_start takes priority over key_valid, so a bit presented together
  // with key_start is dropped.
  assign shift_en = (fsm == LOAD) && key_valid && !key_start;

  lsc_key_shift_reg #(
    .KEY_W (KEY_W)
  ) u_key (
    .clk      (CK),
    .rst      (RST),
    .clr      (key_start),
    .shift_en (shift_en),
    .bit_in   (key_bit),
    .key      (key_r),
    .done     (key_done)
  );

  always_comb begin
    fb        = (^(state_r & TAPS)) ^ (^G);
    raw       = {state_r[STATE_W-2:0], fb};
    state_nxt = '0;
    for (int unsigned i = 0; i < STATE_W; i++) begin
      state_nxt[i] = lsc_key_gate(raw[i], key_r[i], KEY_POL[i]);
    end
  end

  always_comb begin
    out = '0;
    if (out_valid) begin
      for (int unsigned j = 0; j < OUT_W; j++) begin
        out[j] = lsc_key_gate(~state_r[STATE_W-1-j], key_r[STATE_W+j], KEY_POL[STATE_W+j]);
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      fsm       <= IDLE;
      state_r   <= RESET_STATE;
      key_busy  <= 1'b0;
      out_valid <= 1'b0;
    end else if (key_start) begin
      fsm       <= LOAD;
      state_r   <= RESET_STATE;
      key_busy  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        LOAD: begin
          if (key_done) begin
            fsm       <= RUN;
            key_busy  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          state_r <= state_nxt;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_locked_seq_core.sv
module tb_locked_seq_core;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] G = '0;
  logic       key_start = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_bit = 1'b0;
  logic       key_busy;
  logic       out_valid;
  logic [0:0] out;

  int checks = 0;
  int failures = 0;

  localparam int unsigned POL  = 11;  // 4'b1011, also the correct key
  localparam int unsigned TAPV = 6;   // 3'b110

  // Reference model: key kept as a list of received bits, running means
  // "not loading and four bits held".
  bit          kq[$];
  bit          m_loading = 0;
  int unsigned m_state = 0;

  locked_seq_core #(
    .STATE_W     (3),
    .IN_W        (4),
    .OUT_W       (1),
    .KEY_W       (4),
    .TAPS        (3'b110),
    .KEY_POL     (4'b1011),
    .RESET_STATE (3'b000)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .G         (G),
    .key_start (key_start),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .key_busy  (key_busy),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 CK = ~CK;

  function automatic int unsigned key_val();
    int unsigned k = 0;
    foreach (kq[i]) k = k * 2 + kq[i];
    return k;
  endfunction

  function automatic bit running();
    return !m_loading && kq.size() == 4;
  endfunction

  function automatic int unsigned exp_out();
    int unsigned k = key_val();
    if (!running()) return 0;
    return (((m_state >> 2) & 1) ^ 1 ^ ((k >> 3) & 1) ^ ((POL >> 3) & 1));
  endfunction

  task automatic model_edge();
    int unsigned fb, raw;
    if (RST) begin
      m_state = 0; kq.delete(); m_loading = 0;
    end else if (key_start) begin
      m_state = 0; kq.delete(); m_loading = 1;
    end else if (m_loading) begin
      if (key_valid) begin
        kq.push_back(key_bit);
        if (kq.size() == 4) m_loading = 0;
      end
    end else if (running()) begin
      fb  = ($countones(m_state & TAPV) + $countones(G)) % 2;
      raw = (m_state * 2 + fb) % 8;
      m_state = raw ^ ((key_val() ^ POL) & 7);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".key_busy"},  32'(key_busy),  32'(m_loading));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(running()));
    chk({tag, ".out"},       32'(out),       exp_out());
    chk({tag, ".state"},     32'(dut.state_r), m_state);
  endtask

  task automatic load_key(input logic [3:0] k);
    key_start = 1; key_valid = 0; tick();
    key_start = 0;
    for (int i = 3; i >= 0; i--) begin
      key_valid = 1; key_bit = k[i]; tick();
    end
    key_valid = 0; key_bit = 0;
  endtask

  initial begin
    // 1: reset with arbitrary G
    RST = 1; G = 4'($urandom);
    tick();
    G = 4'($urandom);
    tick();
    check_all("reset");
    chk("reset.state_const", 32'(dut.state_r), 0);
    chk("reset.key_r", 32'(dut.u_key.key_r), 0);
    RST = 0;

    // 2: correct key
    load_key(4'b1011);
    check_all("ck_loaded");
    chk("ck.out_valid_const", 32'(out_valid), 1);
    G = 4'b0001; tick();
    chk("ck.state_001", 32'(dut.state_r), 1);
    chk("ck.out_1", 32'(out), 1);
    G = 4'b0000; tick();
    chk("ck.state_010", 32'(dut.state_r), 2);
    check_all("ck_run");

    // 5: re-key mid-RUN
    key_start = 1; tick(); key_start = 0;
    chk("rekey.key_busy", 32'(key_busy), 1);
    chk("rekey.out_valid", 32'(out_valid), 0);
    chk("rekey.out", 32'(out), 0);
    chk("rekey.state", 32'(dut.state_r), 0);

    // 3: wrong keys
    load_key(4'b1010);
    G = 4'b0001; tick();
    chk("wk1010.state", 32'(dut.state_r), 0);
    chk("wk1010.out", 32'(out), 1);
    check_all("wk1010");
    load_key(4'b0011);
    chk("wk0011.out", 32'(out), 0);
    check_all("wk0011");

    // 4: stalled load, abort, key_start beating key_valid, reload
    key_start = 1; tick(); key_start = 0;
    key_valid = 1; key_bit = 1; tick();
    key_valid = 0; tick(); tick();
    key_valid = 1; key_bit = 0; tick();
    key_valid = 0; tick();
    check_all("stall");
    chk("stall.key_r", 32'(dut.u_key.key_r), 2);
    key_start = 1; key_valid = 1; key_bit = 1; tick();
    key_start = 0; key_valid = 0;
    chk("abort.key_r", 32'(dut.u_key.key_r), 0);
    chk("abort.cnt", 32'(dut.u_key.cnt), 0);
    check_all("abort");
    load_key(4'b1011);
    G = 4'b0001; tick();
    chk("reload.state_001", 32'(dut.state_r), 1);
    G = 4'b0000; tick();
    chk("reload.state_010", 32'(dut.state_r), 2);

    // 6: reset mid-load, then a stray key_valid in IDLE
    key_start = 1; tick(); key_start = 0;
    key_valid = 1; key_bit = 1; tick();
    key_bit = 1; tick();
    key_valid = 0;
    RST = 1; tick(); RST = 0;
    chk("rstload.key_busy", 32'(key_busy), 0);
    chk("rstload.key_r", 32'(dut.u_key.key_r), 0);
    key_valid = 1; key_bit = 1; tick(); key_valid = 0;
    chk("idle_valid.key_r", 32'(dut.u_key.key_r), 0);
    check_all("idle_valid");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST       = ($urandom_range(0, 99) == 0);
      key_start = ($urandom_range(0, 29) == 0);
      key_valid = ($urandom_range(0, 9) < 7);
      key_bit   = 1'($urandom);
      G         = 4'($urandom);
      tick();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
